// File: rtl/nonce_scheduler_if.sv
// Handshake between nonce_scheduler (master) and the sequential double-SHA256 header core (slave).
// hash_start is a one-cycle request; hash_done is a one-cycle response qualifying hash_digest.
interface nonce_scheduler_if;
    logic [639:0] hash_hdr;
    logic         hash_start;
    logic         hash_done;
    logic [255:0] hash_digest;

    modport master (output hash_hdr, hash_start, input  hash_done, hash_digest);
    modport slave  (input  hash_hdr, hash_start, output hash_done, hash_digest);
endinterface

// File: rtl/nonce_scheduler.sv
// Nonce search sequencer: issues one header per nonce to a serial double-SHA256 core and ends on
// the first digest at or below target, the end of the range, a stop request, or a core timeout.
module nonce_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_W          = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic [639:0]      i_header_tmpl,
    input  logic [255:0]      i_target,
    input  logic [31:0]       i_nonce_first,
    input  logic [31:0]       i_nonce_last,
    nonce_scheduler_if.master core,
    output logic              o_busy,
    output logic              o_found,
    output logic [31:0]       o_found_nonce,
    output logic [255:0]      o_found_hash,
    output logic              o_exhausted,
    output logic              o_aborted,
    output logic              o_error,
    output logic [CNT_W-1:0]  o_hashes_done
);
    localparam int unsigned      TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_DONE} state_t;

    state_t             r_state;
    logic [639:32]      r_tmpl;
    logic [255:0]       r_target;
    logic [31:0]        r_nonce;
    logic [31:0]        r_nonce_last;
    logic               r_stop_pend;
    logic [TMO_W-1:0]   r_tmo;
    logic [255:0]       r_digest;
    logic [639:0]       r_hash_hdr;
    logic               r_hash_start;
    logic               r_found;
    logic [31:0]        r_found_nonce;
    logic [255:0]       r_found_hash;
    logic               r_exhausted;
    logic               r_aborted;
    logic               r_error;
    logic [CNT_W-1:0]   r_hashes_done;
    logic [31:0]        w_nonce_next;
    logic               w_unused_nonce_field;

    // The template's own nonce field is always replaced by the scheduled nonce.
    assign w_unused_nonce_field = ^i_header_tmpl[31:0];
    assign w_nonce_next         = r_nonce + 32'd1;

    // The core expects the nonce in little-endian byte order inside the header.
    function automatic logic [639:0] build_hdr(input logic [639:32] tmpl, input logic [31:0] nonce);
        return {tmpl, nonce[7:0], nonce[15:8], nonce[23:16], nonce[31:24]};
    endfunction

    // NOTE: every register here, including the wide configuration latches, has a defined reset
    // value so that all outputs read zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_tmpl        <= '0;
            r_target      <= '0;
            r_nonce       <= '0;
            r_nonce_last  <= '0;
            r_stop_pend   <= 1'b0;
            r_tmo         <= '0;
            r_digest      <= '0;
            r_hash_hdr    <= '0;
            r_hash_start  <= 1'b0;
            r_found       <= 1'b0;
            r_found_nonce <= '0;
            r_found_hash  <= '0;
            r_exhausted   <= 1'b0;
            r_aborted     <= 1'b0;
            r_error       <= 1'b0;
            r_hashes_done <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below reads the
            // pre-edge state and the default on r_hash_start makes it a clean one-cycle pulse.
            r_hash_start <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_tmpl        <= i_header_tmpl[639:32];
                        r_target      <= i_target;
                        r_nonce       <= i_nonce_first;
                        r_nonce_last  <= i_nonce_last;
                        r_stop_pend   <= 1'b0;
                        r_found       <= 1'b0;
                        r_exhausted   <= 1'b0;
                        r_aborted     <= 1'b0;
                        r_error       <= 1'b0;
                        r_hashes_done <= '0;
                        r_hash_hdr    <= build_hdr(i_header_tmpl[639:32], i_nonce_first);
                        r_hash_start  <= 1'b1;
                        r_state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_tmo   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (core.hash_done) begin
                        r_digest <= core.hash_digest;
                        r_state  <= S_CHECK;
                    end else if (r_tmo == TMO_LAST) begin
                        r_error <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                S_CHECK: begin
                    if (r_hashes_done != '1) r_hashes_done <= r_hashes_done + CNT_W'(1);
                    // A win outranks both end-of-range and a pending stop.
                    if (r_digest <= r_target) begin
                        r_found       <= 1'b1;
                        r_found_nonce <= r_nonce;
                        r_found_hash  <= r_digest;
                        r_state       <= S_DONE;
                    end else if (r_nonce == r_nonce_last) begin
                        r_exhausted <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (r_stop_pend || i_stop) begin
                        r_aborted <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_nonce      <= w_nonce_next;
                        r_hash_hdr   <= build_hdr(r_tmpl, w_nonce_next);
                        r_hash_start <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (o_busy && i_stop) r_stop_pend <= 1'b1;
        end
    end

    assign o_busy           = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_CHECK);
    assign core.hash_hdr    = r_hash_hdr;
    assign core.hash_start  = r_hash_start;
    assign o_found          = r_found;
    assign o_found_nonce    = r_found_nonce;
    assign o_found_hash     = r_found_hash;
    assign o_exhausted      = r_exhausted;
    assign o_aborted        = r_aborted;
    assign o_error          = r_error;
    assign o_hashes_done    = r_hashes_done;
endmodule
